// File: rtl/pe_layer_sched.sv
// Layer sequencer for a single combinational PE neuron: latches the layer input,
// walks neuron indices through parameter memory, and streams each PE result out.
module pe_layer_sched #(
    parameter int N_IN = 62,
    parameter int DW   = 8,
    parameter int AW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW:0]          num_neurons,
    input  logic [N_IN*DW-1:0]   in_vec,
    output logic                 mem_rd,
    output logic [AW-1:0]        mem_addr,
    input  logic [N_IN*DW-1:0]   mem_weight,
    input  logic [DW-1:0]        mem_bias,
    output logic [N_IN*DW-1:0]   pe_in,
    output logic [N_IN*DW-1:0]   pe_weight,
    output logic [DW-1:0]        pe_bias,
    input  logic [DW-1:0]        pe_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        out_addr,
    output logic [DW-1:0]        out_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EVAL,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] IDX_ONE = 1;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [N_IN*DW-1:0]  pe_in_q, pe_in_d;
    logic [N_IN*DW-1:0]  pe_weight_q, pe_weight_d;
    logic [DW-1:0]       pe_bias_q, pe_bias_d;
    logic                out_valid_q, out_valid_d;
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                last_neuron;

    // Compare on AW+1 bits so a full 2^AW layer ends at idx 2^AW-1 without wrapping.
    assign last_neuron = ({1'b0, idx_q} == (cnt_q - CNT_ONE));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pe_in_d     = pe_in_q;
        pe_weight_d = pe_weight_q;
        pe_bias_d   = pe_bias_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_neurons != '0) begin
                        pe_in_d = in_vec;
                        cnt_d   = num_neurons;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                pe_weight_d = mem_weight;
                pe_bias_d   = mem_bias;
                state_d     = S_EVAL;
            end
            S_EVAL: begin
                out_data_d  = pe_out;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_neuron) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            pe_in_q     <= '0;
            pe_weight_q <= '0;
            pe_bias_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pe_in_q     <= pe_in_d;
            pe_weight_q <= pe_weight_d;
            pe_bias_q   <= pe_bias_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    // Strobes decode straight from state so reset clears them asynchronously.
    assign mem_rd    = (state_q == S_FETCH);
    assign mem_addr  = mem_rd ? idx_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pe_in     = pe_in_q;
    assign pe_weight = pe_weight_q;
    assign pe_bias   = pe_bias_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pe_layer_sched.sv
// Bench for pe_layer_sched: stub PE (pe_out = pe_bias), array-backed parameter memory,
// reference model tracks expected read/result order and layer timing per run.
module tb_pe_layer_sched;

    localparam int N_IN = 62;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int VW   = N_IN * DW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [AW:0]    num_neurons;
    logic [VW-1:0]  in_vec;
    logic           mem_rd;
    logic [AW-1:0]  mem_addr;
    logic [VW-1:0]  mem_weight;
    logic [DW-1:0]  mem_bias;
    logic [VW-1:0]  pe_in;
    logic [VW-1:0]  pe_weight;
    logic [DW-1:0]  pe_bias;
    logic [DW-1:0]  pe_out;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_addr;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic           done;

    logic [VW-1:0]  wmem [256];
    logic [DW-1:0]  bmem [256];

    int n_cmp = 0;
    int n_err = 0;

    pe_layer_sched #(.N_IN(N_IN), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_neurons(num_neurons),
        .in_vec(in_vec), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_weight(mem_weight), .mem_bias(mem_bias), .pe_in(pe_in),
        .pe_weight(pe_weight), .pe_bias(pe_bias), .pe_out(pe_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign pe_out = pe_bias;

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Memory answers one cycle after the read strobe; junk otherwise so stray sampling shows.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_weight <= wmem[mem_addr];
            mem_bias   <= bmem[mem_addr];
        end else begin
            mem_weight <= rvec();
            mem_bias   <= DW'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_mem_rd"},    VW'(mem_rd),    '0);
        chk({pfx, "_mem_addr"},  VW'(mem_addr),  '0);
        chk({pfx, "_pe_in"},     pe_in,          '0);
        chk({pfx, "_pe_weight"}, pe_weight,      '0);
        chk({pfx, "_pe_bias"},   VW'(pe_bias),   '0);
        chk({pfx, "_out_valid"}, VW'(out_valid), '0);
        chk({pfx, "_out_addr"},  VW'(out_addr),  '0);
        chk({pfx, "_out_data"},  VW'(out_data),  '0);
        chk({pfx, "_busy"},      VW'(busy),      '0);
        chk({pfx, "_done"},      VW'(done),      '0);
    endtask

    // mode 0: ready always high (exact timing checked); 1: random ready; 2: ready low 5 cycles at first result
    task automatic run_layer(input int n, input logic [VW-1:0] vec, input int mode, input bit restart);
        int t, rd, hs, hold;
        bit fin, pv, pr;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        @(negedge clk);
        start = 1'b1; num_neurons = (AW+1)'(n); in_vec = vec; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; num_neurons = (AW+1)'($urandom); in_vec = rvec();
        t = 1; rd = 0; hs = 0; hold = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
        while (!fin) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && hs == 0 && hold < 5) begin
                        out_ready = 1'b0; hold++;
                    end else out_ready = 1'b1;
                end
            endcase
            if (mem_rd) begin
                chk("mem_addr", VW'(mem_addr), VW'(rd));
                rd++;
                chk("rd_before_handshake", VW'(rd <= hs + 1), VW'(1));
                chk("pe_in_latched", pe_in, vec);
            end
            if (mode == 0 && n > 0)
                chk("mem_rd_timing", VW'(mem_rd), VW'((t % 4 == 1) && (t < 4*n)));
            if (pv && !pr) begin
                chk("hold_valid", VW'(out_valid), VW'(1));
                chk("hold_addr",  VW'(out_addr),  VW'(pa));
                chk("hold_data",  VW'(out_data),  VW'(pd));
            end
            if (out_valid) begin
                chk("valid_overrun", VW'(hs < n), VW'(1));
                chk("out_addr",  VW'(out_addr), VW'(hs % 256));
                chk("out_data",  VW'(out_data), VW'(bmem[hs % 256]));
                chk("pe_weight", pe_weight,     wmem[hs % 256]);
                if (out_ready) hs++;
            end
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
            if (done) begin
                chk("done_results", VW'(hs), VW'(n));
                chk("done_reads",   VW'(rd), VW'(n));
                if (mode == 0) chk("done_cycle", VW'(t), VW'(4*n + 1));
                fin = 1'b1;
            end else begin
                chk("busy", VW'(busy), VW'(1));
            end
            if (!fin && t > 12*n + 100) begin
                chk("timeout", VW'(0), VW'(1));
                fin = 1'b1;
            end
            if (restart && t == 6) begin
                start = 1'b1; num_neurons = (AW+1)'(7); in_vec = ~vec;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        chk("busy_drop",  VW'(busy), VW'(0));
        chk("done_pulse", VW'(done), VW'(0));
        if (n > 0) chk("pe_in_hold", pe_in, vec);
    endtask

    initial begin
        logic [VW-1:0] v;
        rst_n = 1'b0; start = 1'b0; num_neurons = '0; in_vec = '0; out_ready = 1'b0;
        for (int k = 0; k < 256; k++) begin
            wmem[k] = rvec();
            bmem[k] = DW'(k + 1);
        end
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        run_layer(3, rvec(), 0, 1'b0);
        run_layer(2, rvec(), 2, 1'b0);
        run_layer(0, rvec(), 0, 1'b0);
        run_layer(3, rvec(), 0, 1'b1);

        // Abort during WAIT of neuron 1 (cycle 6 after start).
        v = rvec();
        @(negedge clk);
        start = 1'b1; num_neurons = (AW+1)'(3); in_vec = v; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_busy", VW'(busy), VW'(1));
        chk("pre_abort_pe_in", pe_in, v);
        #1 rst_n = 1'b0;
        #1 chk_zero("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", VW'(done), VW'(0));
        end
        rst_n = 1'b1;
        run_layer(3, rvec(), 0, 1'b0);

        run_layer(256, rvec(), 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 256; k++) begin
                wmem[k] = rvec();
                bmem[k] = DW'($urandom);
            end
            run_layer(int'($urandom_range(1, 20)), rvec(), 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
